// File: rtl/fp32_mul_operand_unpack.sv
// FP32 multiplier operand unpack stage: classifies operand pairs, builds special-case
// bypass results, and buffers them in a 2-entry FIFO. Optional macro FP_UNPACK_STATS_EN
// adds a saturating special-case event counter (special_count) with a clear input (stats_clr).
module fp32_mul_operand_unpack #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
`ifdef FP_UNPACK_STATS_EN
  , parameter int unsigned CNT_WIDTH    = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_a,
  input  logic [31:0]               in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sign_x,
  output logic                      sign_y,
  output logic [EXP_WIDTH-1:0]      exp_x,
  output logic [EXP_WIDTH-1:0]      exp_y,
  output logic [MANTISSA_WIDTH-1:0] mantissa_x,
  output logic [MANTISSA_WIDTH-1:0] mantissa_y,
  output logic                      special,
  output logic [31:0]               special_result,
  output logic                      invalid
`ifdef FP_UNPACK_STATS_EN
  , input  logic                    stats_clr
  , output logic [CNT_WIDTH-1:0]    special_count
`endif
);

  localparam int unsigned W = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic                      sign_x;
    logic [EXP_WIDTH-1:0]      exp_x;
    logic [MANTISSA_WIDTH-1:0] man_x;
    logic                      sign_y;
    logic [EXP_WIDTH-1:0]      exp_y;
    logic [MANTISSA_WIDTH-1:0] man_y;
    logic                      special;
    logic [W-1:0]              special_result;
    logic                      invalid;
  } entry_t;

  entry_t     head, tail, new_entry;
  logic [1:0] count;
  logic       push, pop;

  logic                      sa, sb, s;
  logic [EXP_WIDTH-1:0]      ea, eb;
  logic [MANTISSA_WIDTH-1:0] ma, mb;
  logic                      nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign sa = in_a[W-1];
  assign sb = in_b[W-1];
  assign s  = sa ^ sb;
  assign ea = in_a[W-2 -: EXP_WIDTH];
  assign eb = in_b[W-2 -: EXP_WIDTH];
  assign ma = in_a[MANTISSA_WIDTH-1:0];
  assign mb = in_b[MANTISSA_WIDTH-1:0];

  assign nan_a  = (ea == '1) && (ma != '0);
  assign nan_b  = (eb == '1) && (mb != '0);
  assign inf_a  = (ea == '1) && (ma == '0);
  assign inf_b  = (eb == '1) && (mb == '0);
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);

  // Classify the incoming pair; denormals are flushed to signed zero.
  always_comb begin
    new_entry        = '0;
    new_entry.sign_x = sa;
    new_entry.exp_x  = zero_a ? '0 : ea;
    new_entry.man_x  = zero_a ? '0 : ma;
    new_entry.sign_y = sb;
    new_entry.exp_y  = zero_b ? '0 : eb;
    new_entry.man_y  = zero_b ? '0 : mb;
    if (nan_a || nan_b) begin
      new_entry.special        = 1'b1;
      new_entry.special_result = QNAN;
      new_entry.invalid        = 1'b1;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      new_entry.special        = 1'b1;
      new_entry.special_result = QNAN;
      new_entry.invalid        = 1'b1;
    end else if (inf_a || inf_b) begin
      new_entry.special        = 1'b1;
      new_entry.special_result = {s, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
    end else if (zero_a || zero_b) begin
      new_entry.special        = 1'b1;
      new_entry.special_result = {s, (W-1)'(0)};
    end
  end

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Shift-style FIFO: head always holds the oldest entry so outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= new_entry;
          else               tail <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          tail  <= '0;
          count <= count - 2'd1;
        end
        // Push with pop only happens at count 1 (count 2 blocks push).
        2'b11: head <= new_entry;
        default: ;
      endcase
    end
  end

  assign sign_x         = head.sign_x;
  assign sign_y         = head.sign_y;
  assign exp_x          = head.exp_x;
  assign exp_y          = head.exp_y;
  assign mantissa_x     = head.man_x;
  assign mantissa_y     = head.man_y;
  assign special        = head.special;
  assign special_result = head.special_result;
  assign invalid        = head.invalid;

`ifdef FP_UNPACK_STATS_EN
  // Saturating count of special entries leaving the stage; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      special_count <= '0;
    end else if (stats_clr) begin
      special_count <= '0;
    end else if (pop && head.special && (special_count != '1)) begin
      special_count <= special_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fp32_mul_operand_unpack.sv
// Directed bench for fp32_mul_operand_unpack with hand-computed expected values.
module tb_fp32_mul_operand_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic        sign_x, sign_y;
  logic [7:0]  exp_x, exp_y;
  logic [22:0] mantissa_x, mantissa_y;
  logic        special, invalid;
  logic [31:0] special_result;
`ifdef FP_UNPACK_STATS_EN
  logic        stats_clr;
  logic [15:0] special_count;
`endif

  int checks = 0;
  int errors = 0;

  fp32_mul_operand_unpack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_x(sign_x), .sign_y(sign_y), .exp_x(exp_x), .exp_y(exp_y),
    .mantissa_x(mantissa_x), .mantissa_y(mantissa_y),
    .special(special), .special_result(special_result), .invalid(invalid)
`ifdef FP_UNPACK_STATS_EN
    , .stats_clr(stats_clr), .special_count(special_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Push one pair into an empty stage with out_ready high; head is visible after the call.
  task automatic single(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b1;
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
`ifdef FP_UNPACK_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_special", 32'(special), 32'd0);
    chk("rst_exp_x", 32'(exp_x), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // 1.5 * 2.0: both normal
    single(32'h3FC00000, 32'h40000000);
    chk("norm_out_valid", 32'(out_valid), 32'd1);
    chk("norm_exp_x", 32'(exp_x), 32'h7F);
    chk("norm_man_x", 32'(mantissa_x), 32'h400000);
    chk("norm_exp_y", 32'(exp_y), 32'h80);
    chk("norm_man_y", 32'(mantissa_y), 32'h0);
    chk("norm_special", 32'(special), 32'd0);
    chk("norm_result", special_result, 32'h0);
    tick();
    chk("norm_drained", 32'(out_valid), 32'd0);

    // Backpressure: three pairs with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40400000;
    tick();
    chk("bp_ready_c1", 32'(in_ready), 32'd1);
    in_a = 32'hC0A00000; in_b = 32'h3F800000;
    tick();
    chk("bp_ready_c2", 32'(in_ready), 32'd0);
    in_a = 32'h7F800000; in_b = 32'h80000000;
    tick();
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_head", 32'(exp_y), 32'h80);
    chk("bp_hold_man_y", 32'(mantissa_y), 32'h400000);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    chk("bp_pop1_sign_x", 32'(sign_x), 32'd1);
    chk("bp_pop1_exp_x", 32'(exp_x), 32'h81);
    chk("bp_pop1_man_x", 32'(mantissa_x), 32'h200000);
    tick();
    in_valid = 1'b0;
    chk("pp_out_valid", 32'(out_valid), 32'd1);
    chk("pp_in_ready", 32'(in_ready), 32'd1);
    chk("infzero_special", 32'(special), 32'd1);
    chk("infzero_result", special_result, 32'h7FC00000);
    chk("infzero_invalid", 32'(invalid), 32'd1);
    chk("infzero_exp_x_raw", 32'(exp_x), 32'hFF);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // -Inf * 1.0
    single(32'hFF800000, 32'h3F800000);
    chk("ninf_special", 32'(special), 32'd1);
    chk("ninf_result", special_result, 32'hFF800000);
    chk("ninf_invalid", 32'(invalid), 32'd0);
    tick();

    // Denormal * -3.0: flushed to zero, sign negative
    single(32'h00000001, 32'hC0400000);
    chk("den_special", 32'(special), 32'd1);
    chk("den_result", special_result, 32'h80000000);
    chk("den_exp_x", 32'(exp_x), 32'h0);
    chk("den_man_x", 32'(mantissa_x), 32'h0);
    chk("den_sign_y", 32'(sign_y), 32'd1);
    chk("den_man_y", 32'(mantissa_y), 32'h400000);
    chk("den_invalid", 32'(invalid), 32'd0);
    tick();

    // sNaN * 0: NaN has priority over zero, mantissa passed raw
    single(32'h7F800001, 32'h00000000);
    chk("nan_result", special_result, 32'h7FC00000);
    chk("nan_invalid", 32'(invalid), 32'd1);
    chk("nan_man_x_raw", 32'(mantissa_x), 32'h1);
    tick();

    // +Inf * -Inf
    single(32'h7F800000, 32'hFF800000);
    chk("infinf_result", special_result, 32'hFF800000);
    chk("infinf_invalid", 32'(invalid), 32'd0);
    tick();

    // Reset with two entries buffered takes effect without a clock edge
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'hBF800000;
    tick(); tick();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_sign_y", 32'(sign_y), 32'd0);
    chk("arst_exp_x", 32'(exp_x), 32'd0);
    tick();
    rst = 1'b0;

`ifdef FP_UNPACK_STATS_EN
    // Three special pops, then a clear coinciding with a special pop
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h00000000; in_b = 32'h3F800000;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tick();
    chk("stats_count3", 32'(special_count), 32'd3);
    single(32'h00000000, 32'h3F800000);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("stats_clr_prio", 32'(special_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
